// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between the core writeback (C) and the
// long-latency result path (L), with a per-register busy scoreboard for L results.
module regfile_wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            c_valid,
    input  logic [AW-1:0]   c_rd,
    input  logic [XLEN-1:0] c_data,
    output logic            c_ready,
    input  logic            l_valid,
    input  logic [AW-1:0]   l_rd,
    input  logic [XLEN-1:0] l_data,
    output logic            l_ready,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_rd,
    output logic            rsv_ready,
    input  logic [AW-1:0]   q_rs1,
    input  logic [AW-1:0]   q_rs2,
    input  logic [AW-1:0]   q_rd,
    output logic            hazard,
    output logic            rf_we,
    output logic [AW-1:0]   rf_addr,
    output logic [XLEN-1:0] rf_data,
    output logic [NREG-1:0] busy,
    output logic            err
);

    localparam logic [3:0]      MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [AW-1:0]   X0         = {AW{1'b0}};
    localparam logic [NREG-1:0] ONE_HOT0   = {{(NREG-1){1'b0}}, 1'b1};

    logic [NREG-1:0] busy_r;
    logic [3:0]      wait_cnt_r;
    logic            err_r;

    logic            c_elig_s;
    logic            starve_s;
    logic            c_grant_s;
    logic            l_grant_s;
    logic            rsv_ok_s;
    logic [NREG-1:0] clr_mask_s;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] busy_nxt_s;
    logic [3:0]      wait_nxt_s;
    logic            err_set_s;

    // Grant selection: C by default, L once it has been refused MAX_WAIT times.
    always_comb begin
        c_elig_s = c_valid && ((c_rd == X0) || (busy_r[c_rd] == 1'b0));
        starve_s = (wait_cnt_r == MAX_WAIT_C);
        if (!rst_n) begin
            c_grant_s = 1'b0;
            l_grant_s = 1'b0;
        end else if (c_elig_s && l_valid) begin
            c_grant_s = !starve_s;
            l_grant_s = starve_s;
        end else begin
            c_grant_s = c_elig_s;
            l_grant_s = l_valid;
        end
    end

    // Write-port mux from the granted requester; x0 writes are consumed silently.
    always_comb begin
        if (c_grant_s) begin
            rf_addr = c_rd;
            rf_data = c_data;
        end else if (l_grant_s) begin
            rf_addr = l_rd;
            rf_data = l_data;
        end else begin
            rf_addr = X0;
            rf_data = {XLEN{1'b0}};
        end
        rf_we = (c_grant_s || l_grant_s) && (rf_addr != X0);
    end

    // Scoreboard, starvation counter and error next-state; a set beats a same-cycle clear.
    always_comb begin
        rsv_ok_s   = rst_n && ((rsv_rd == X0) || (busy_r[rsv_rd] == 1'b0));
        clr_mask_s = (l_grant_s && (l_rd != X0)) ? (ONE_HOT0 << l_rd) : {NREG{1'b0}};
        set_mask_s = (rsv_valid && rsv_ok_s && (rsv_rd != X0)) ? (ONE_HOT0 << rsv_rd)
                                                               : {NREG{1'b0}};
        busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
        if (l_valid && !l_grant_s) begin
            wait_nxt_s = starve_s ? wait_cnt_r : (wait_cnt_r + 4'd1);
        end else begin
            wait_nxt_s = 4'd0;
        end
        err_set_s = (l_grant_s && (l_rd != X0) && (busy_r[l_rd] == 1'b0))
                 || (rsv_valid && !rsv_ok_s);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r     <= {NREG{1'b0}};
            wait_cnt_r <= 4'd0;
            err_r      <= 1'b0;
        end else begin
            busy_r     <= busy_nxt_s;
            wait_cnt_r <= wait_nxt_s;
            err_r      <= err_r || err_set_s;
        end
    end

    assign c_ready   = c_grant_s;
    assign l_ready   = l_grant_s;
    assign rsv_ready = rsv_ok_s;
    assign hazard    = rst_n && (((q_rs1 != X0) && busy_r[q_rs1])
                              || ((q_rs2 != X0) && busy_r[q_rs2])
                              || ((q_rd  != X0) && busy_r[q_rd]));
    assign busy      = busy_r;
    assign err       = err_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the rules.
module tb_regfile_wb_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_valid, l_valid, rsv_valid;
    logic [4:0]  c_rd, l_rd, rsv_rd, q_rs1, q_rs2, q_rd;
    logic [31:0] c_data, l_data;
    logic        c_ready, l_ready, rsv_ready, hazard, rf_we, err;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] busy;

    int errors = 0;
    int checks = 0;

    // Model state: which registers await an L result, refusal count, sticky error.
    bit mb[32];
    int mw;
    bit me;

    regfile_wb_arbiter #(.XLEN(32), .NREG(32), .AW(5), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_valid(c_valid), .c_rd(c_rd), .c_data(c_data), .c_ready(c_ready),
        .l_valid(l_valid), .l_rd(l_rd), .l_data(l_data), .l_ready(l_ready),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rsv_ready(rsv_ready),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .hazard(hazard),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst_n = 1'b1; c_valid = 1'b0; l_valid = 1'b0; rsv_valid = 1'b0;
        c_rd = 5'd0; l_rd = 5'd0; rsv_rd = 5'd0; q_rs1 = 5'd0; q_rs2 = 5'd0; q_rd = 5'd0;
        c_data = 32'd0; l_data = 32'd0;
    endtask

    // Check all outputs against the model, clock once, advance the model.
    task automatic cycle(input string tag);
        bit          c_ok, cg, lg, rok, hz, we;
        logic [4:0]  a;
        logic [31:0] d, bv;
        #1;
        c_ok = c_valid && (c_rd == 0 || !mb[c_rd]);
        cg = 0; lg = 0;
        if (rst_n) begin
            if (c_ok && l_valid) begin
                lg = (mw == MAX_WAIT);
                cg = !lg;
            end else begin
                cg = c_ok;
                lg = l_valid;
            end
        end
        a = cg ? c_rd : (lg ? l_rd : 5'd0);
        d = cg ? c_data : (lg ? l_data : 32'd0);
        we = (cg || lg) && a != 0;
        rok = rst_n && (rsv_rd == 0 || !mb[rsv_rd]);
        hz = rst_n && ((q_rs1 != 0 && mb[q_rs1]) || (q_rs2 != 0 && mb[q_rs2]) ||
                       (q_rd != 0 && mb[q_rd]));
        for (int i = 0; i < 32; i++) bv[i] = mb[i];
        chk({tag, ".c_ready"}, 64'(c_ready), 64'(cg));
        chk({tag, ".l_ready"}, 64'(l_ready), 64'(lg));
        chk({tag, ".rsv_ready"}, 64'(rsv_ready), 64'(rok));
        chk({tag, ".rf_we"}, 64'(rf_we), 64'(we));
        chk({tag, ".rf_addr"}, 64'(rf_addr), 64'(a));
        chk({tag, ".rf_data"}, 64'(rf_data), 64'(d));
        chk({tag, ".hazard"}, 64'(hazard), 64'(hz));
        chk({tag, ".busy"}, 64'(busy), 64'(bv));
        chk({tag, ".err"}, 64'(err), 64'(me));
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mb[i] = 0;
            mw = 0;
            me = 0;
        end else begin
            if ((lg && l_rd != 0 && !mb[l_rd]) || (rsv_valid && !rok)) me = 1;
            mw = (l_valid && !lg) ? ((mw < MAX_WAIT) ? mw + 1 : MAX_WAIT) : 0;
            if (lg && l_rd != 0) mb[l_rd] = 0;
            if (rsv_valid && rok && rsv_rd != 0) mb[rsv_rd] = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mb[i] = 0;
        mw = 0;
        me = 0;
        idle();
        // Reset held two cycles with a pending core request.
        rst_n = 1'b0; c_valid = 1'b1; c_rd = 5'd5; c_data = 32'h1234_5678;
        @(negedge clk);
        cycle("rst0");
        cycle("rst1");
        rst_n = 1'b1;
        cycle("rst_release");

        // Core-only writes.
        c_rd = 5'd5; c_data = 32'hDEAD_BEEF;
        #1;
        chk("core_data_const", 64'(rf_data), 64'hDEAD_BEEF);
        cycle("core5");
        c_rd = 5'd0;
        cycle("core_x0");

        // Starvation: L to x7 is forced through after MAX_WAIT refusals.
        idle(); rsv_valid = 1'b1; rsv_rd = 5'd7;
        cycle("rsv7");
        idle(); c_valid = 1'b1; c_rd = 5'd3; c_data = 32'hC3C3_C3C3;
        l_valid = 1'b1; l_rd = 5'd7; l_data = 32'h7777_0007;
        for (int i = 0; i <= MAX_WAIT; i++) begin
            #1;
            chk("starve_l_const", 64'(l_ready), 64'(i == MAX_WAIT));
            cycle("starve");
        end
        idle();
        #1;
        chk("starve_busy7_const", 64'(busy[7]), 64'd0);
        cycle("post_starve");

        // Scoreboard hazard on x9.
        rsv_valid = 1'b1; rsv_rd = 5'd9;
        cycle("rsv9");
        idle(); q_rs2 = 5'd9; c_valid = 1'b1; c_rd = 5'd9; c_data = 32'h9999_0000;
        #1;
        chk("hazard9_const", 64'(hazard), 64'd1);
        cycle("hazard9");
        c_valid = 1'b0; l_valid = 1'b1; l_rd = 5'd9; l_data = 32'h0000_9999;
        cycle("l_write9");
        l_valid = 1'b0; c_valid = 1'b1;
        cycle("clear9");

        // Set/clear collision on x4.
        idle(); rsv_valid = 1'b1; rsv_rd = 5'd4;
        cycle("rsv4");
        l_valid = 1'b1; l_rd = 5'd4; l_data = 32'h4444_0001;
        cycle("collide_busy");
        cycle("collide_free");
        idle(); l_valid = 1'b1; l_rd = 5'd4; l_data = 32'h4444_0002;
        cycle("drain4");

        // Unreserved L write sets the sticky error until reset.
        idle(); rst_n = 1'b0;
        cycle("rst_err");
        idle(); l_valid = 1'b1; l_rd = 5'd12; l_data = 32'h0C0C_0C0C;
        cycle("l_unreserved12");
        idle();
        cycle("err_sticky0");
        cycle("err_sticky1");
        rst_n = 1'b0;
        cycle("rst_clear_err");

        // Randomized traffic, biased toward reserved L destinations.
        idle();
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 79) != 0);
            c_valid   = $urandom_range(0, 1);
            c_rd      = 5'($urandom_range(0, 15));
            c_data    = $urandom;
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_rd    = 5'($urandom_range(0, 15));
            l_valid   = ($urandom_range(0, 2) == 0);
            l_rd      = 5'($urandom_range(0, 15));
            for (int k = 0; k < 16; k++) begin
                if (mb[k] && $urandom_range(0, 3) == 0) l_rd = 5'(k);
            end
            l_data    = $urandom;
            q_rs1     = 5'($urandom_range(0, 15));
            q_rs2     = 5'($urandom_range(0, 15));
            q_rd      = 5'($urandom_range(0, 15));
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file and arbitrates it between two requesters.
- Requester C is the core's single-cycle writeback. Requester L is the long-latency result path (load/mul/div).
- Keeps a per-register busy scoreboard for outstanding L results. Gives the decoder a hazard flag for RAW/WAW stalls.
- Sits between the execute/writeback stage and the register file write inputs (write enable, dest address, write data).

Parameters:
XLEN, 32, data width of write data.
NREG, 32, number of architectural registers.
AW, 5, register address width (log2 NREG).
MAX_WAIT, 4, cycles L may be refused before it gets forced priority (1..15).

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
c_valid  in  1  core writeback request
c_rd  in  AW  core destination register
c_data  in  XLEN  core write data
c_ready  out  1  core request granted this cycle
l_valid  in  1  long-latency result request
l_rd  in  AW  long-latency destination register
l_data  in  XLEN  long-latency write data
l_ready  out  1  long-latency request granted this cycle
rsv_valid  in  1  long op launched; reserve rsv_rd
rsv_rd  in  AW  register to reserve
rsv_ready  out  1  reservation accepted
q_rs1  in  AW  decoder query, source 1
q_rs2  in  AW  decoder query, source 2
q_rd  in  AW  decoder query, destination
hazard  out  1  any queried register busy
rf_we  out  1  register file write enable
rf_addr  out  AW  register file write address
rf_data  out  XLEN  register file write data
busy  out  NREG  scoreboard vector
err  out  1  sticky protocol error

Behaviour:
- Reset (rst_n=0 at clk edge): busy=0, wait_cnt=0, err=0.
- While rst_n=0, force c_ready, l_ready, rsv_ready, rf_we and hazard to 0. Drive rf_addr=0, rf_data=0.
- Write path is combinational, zero latency. Requests are sampled and written at the same clk edge the register file samples.
- Eligibility:
  - C is eligible when c_valid=1 and (c_rd==0 or busy[c_rd]==0). C must never overwrite a pending L result.
  - L is eligible when l_valid=1.
- Grant:
  - Only one eligible requester: grant it.
  - Both eligible: grant C, unless wait_cnt==MAX_WAIT, in which case grant L.
  - Neither eligible: rf_we=0, rf_addr/rf_data hold 0.
- Exactly one of c_ready/l_ready is high per cycle, or neither.
- rf_addr/rf_data come from the granted requester.
- rf_we = grant and (rf_addr!=0). A granted x0 write is consumed (ready=1) with no write.
- wait_cnt:
  - +1 (saturating at MAX_WAIT) each cycle l_valid=1 and l_ready=0.
  - Clears to 0 when l_ready=1 or l_valid=0.
- Scoreboard:
  - rsv_ready = (rsv_rd==0) or busy[rsv_rd]==0. Only one outstanding L result per register.
  - On rsv_valid&rsv_ready with rsv_rd!=0: set busy[rsv_rd] next edge.
  - On l_ready with l_rd!=0: clear busy[l_rd] next edge.
  - Same register set and cleared in the same cycle: set wins (back-to-back reuse).
  - Reserving x0 is accepted and has no effect.
- hazard = (q_rs1!=0 & busy[q_rs1]) | (q_rs2!=0 & busy[q_rs2]) | (q_rd!=0 & busy[q_rd]). Combinational, reflects the current busy vector. No bypass of the same-cycle clear.
- err is sticky (set at the edge, cleared only by reset). It sets on:
  - an L grant with l_rd!=0 and busy[l_rd]==0 (unreserved result), or
  - rsv_valid with rsv_ready=0.
  - Erroneous L writes are still performed.
- Reset mid-operation: every reservation is dropped. Any in-flight requester must re-request after reset.

Test Plan:
- Reset: hold rst_n=0 two cycles with c_valid=1 -> c_ready=0, rf_we=0, busy=0, err=0. Release -> next cycle c_ready=1.
- Core only: c_valid=1, c_rd=5, c_data=0xDEADBEEF -> same cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF, c_ready=1. With c_rd=0 -> c_ready=1, rf_we=0.
- Starvation: reserve x7, then hold c_valid=1 (c_rd=3) and l_valid=1 (l_rd=7) continuously -> C granted cycles 0-3, L granted cycle 4 (MAX_WAIT=4), busy[7]=0 after that edge, wait_cnt=0.
- Scoreboard hazard: reserve x9 -> next cycle busy[9]=1; q_rs2=9 -> hazard=1; c_valid with c_rd=9 -> c_ready=0. After the L write to x9 -> hazard=0, c_ready=1.
- Set/clear collision: busy[4]=1, same cycle l_ready write to x4 and rsv_valid rsv_rd=4 -> rsv_ready=0 (still busy), err=1. Repeat next cycle with busy[4]=0 and a simultaneous L write to x4 -> rsv_ready=1, busy[4]=1 after the edge (set wins).
- Protocol error: L write to x12 with busy[12]=0 -> rf_we=1, rf_addr=12, err=1, and err stays 1 until rst_n=0.
